// File: rtl/spi_ram_ctrl_if.sv
// Bus bundle between the SPI command controller, the SPI slave word
// interface and the single-port 256x8 RAM.
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;

    // Controller side
    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );

    // SPI slave / RAM side
    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command controller: decodes 10-bit SPI words into RAM address/data
// commands, sequences RAM strobes, returns read bytes over tx handshake
// and keeps sticky protocol-error flags.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a command word, only state accepting rx
// WRITE    | mem_we pulse to wr_addr with latched payload
// RD_ISSUE | mem_re pulse to rd_addr
// RD_WAIT  | counting RAM read latency, captures mem_rdata
// TX       | tx_valid held until tx_ready
module spi_ram_ctrl #(
    parameter int RD_LAT   = 1,
    parameter bit AUTO_INC = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    spi_ram_ctrl_if.slave bus,
    output logic          busy,
    output logic          overrun,
    output logic          rd_err,
    input  logic          clr_status
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        TX       = 3'd4
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Down-counter reload; RD_LAT is limited to 1..4 so two bits suffice.
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t     state, state_nx;
    logic [7:0] wr_addr, rd_addr;
    logic       rd_addr_ok;
    logic [7:0] addr_q, wdata_q, tx_data_q;
    logic       tx_valid_q;
    logic [1:0] lat_cnt;

    logic [1:0] opcode;
    logic [7:0] payload;
    logic       accept;
    logic       rd_err_set;
    logic       overrun_set;

    assign opcode      = bus.rx_data[9:8];
    assign payload     = bus.rx_data[7:0];
    assign accept      = bus.rx_valid && (state == IDLE);
    assign rd_err_set  = accept && (opcode == OP_RD_DATA) && !rd_addr_ok;
    assign overrun_set = bus.rx_valid && (state != IDLE);

    // Strobes come straight from state; gating with rst keeps the reset
    // cycle free of any RAM access.
    assign bus.mem_we    = (state == WRITE) && !rst;
    assign bus.mem_re    = (state == RD_ISSUE) && !rst;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign busy          = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (opcode == OP_WR_DATA)                    state_nx = WRITE;
                    else if (opcode == OP_RD_DATA && rd_addr_ok) state_nx = RD_ISSUE;
                end
            end
            WRITE:    state_nx = IDLE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  if (lat_cnt == 2'd0) state_nx = TX;
            TX:       if (bus.tx_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Address registers, RAM address/data latches, latency timer and tx holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= 8'h00;
            rd_addr    <= 8'h00;
            rd_addr_ok <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            lat_cnt    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        case (opcode)
                            OP_WR_ADDR: wr_addr <= payload;
                            OP_WR_DATA: begin
                                addr_q  <= wr_addr;
                                wdata_q <= payload;
                            end
                            OP_RD_ADDR: begin
                                rd_addr    <= payload;
                                rd_addr_ok <= 1'b1;
                            end
                            OP_RD_DATA: if (rd_addr_ok) addr_q <= rd_addr;
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    if (AUTO_INC) wr_addr <= wr_addr + 8'd1;
                end
                RD_ISSUE: lat_cnt <= LAT_M1;
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        tx_data_q  <= bus.mem_rdata;
                        tx_valid_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                TX: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (AUTO_INC) rd_addr <= rd_addr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status flags; a new error event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            overrun <= overrun_set | (overrun & ~clr_status);
            rd_err  <= rd_err_set  | (rd_err  & ~clr_status);
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: stimulus pushes expected RAM strobes and tx bytes,
// negedge monitors pop and compare whenever a DUT presents one.
// dut_a: RD_LAT=1, AUTO_INC=0.  dut_b: RD_LAT=3, AUTO_INC=1.
module tb_spi_ram_ctrl;

    localparam int K_WE = 0;
    localparam int K_RE = 1;
    localparam int K_TX = 2;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic clr_a, clr_b;
    logic busy_a, overrun_a, rd_err_a;
    logic busy_b, overrun_b, rd_err_b;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    ev_t q_a[$];
    ev_t q_b[$];

    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [7:0] rp_a;
    logic [7:0] rp_b0, rp_b1, rp_b2;

    spi_ram_ctrl_if if_a();
    spi_ram_ctrl_if if_b();

    spi_ram_ctrl #(.RD_LAT(1), .AUTO_INC(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .busy(busy_a), .overrun(overrun_a), .rd_err(rd_err_a), .clr_status(clr_a)
    );

    spi_ram_ctrl #(.RD_LAT(3), .AUTO_INC(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .busy(busy_b), .overrun(overrun_b), .rd_err(rd_err_b), .clr_status(clr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: data only appears RD_LAT cycles after mem_re, zero otherwise
    always @(posedge clk) begin
        if (if_a.mem_we) ram_a[if_a.mem_addr] <= if_a.mem_wdata;
        rp_a <= if_a.mem_re ? ram_a[if_a.mem_addr] : 8'h00;
        if (if_b.mem_we) ram_b[if_b.mem_addr] <= if_b.mem_wdata;
        rp_b0 <= if_b.mem_re ? ram_b[if_b.mem_addr] : 8'h00;
        rp_b1 <= rp_b0;
        rp_b2 <= rp_b1;
    end
    assign if_a.mem_rdata = rp_a;
    assign if_b.mem_rdata = rp_b2;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic void push(input int which, input int kind,
                                 input logic [7:0] addr, input logic [7:0] data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endfunction

    task automatic observe(input int which, input int kind,
                           input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        string nm;
        nm = (which == 0) ? "dut_a" : "dut_b";
        n_checks++;
        if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
            n_fail++;
            $display("FAIL %s unexpected event: kind %0d addr %0h data %0h at cycle %0d, none required",
                     nm, kind, addr, data, cyc);
        end else begin
            e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s event: got kind %0d addr %0h data %0h cycle %0d, required kind %0d addr %0h data %0h cycle %0d",
                         nm, kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
            end
        end
    endtask

    // Monitor for dut_a
    always @(negedge clk) begin
        if (if_a.mem_we && if_a.mem_re) chk("a_we_re_exclusive", 1, 0);
        if (if_a.mem_we) observe(0, K_WE, if_a.mem_addr, if_a.mem_wdata);
        if (if_a.mem_re) observe(0, K_RE, if_a.mem_addr, 8'h00);
        if (if_a.tx_valid && if_a.tx_ready) observe(0, K_TX, 8'h00, if_a.tx_data);
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        if (if_b.mem_we && if_b.mem_re) chk("b_we_re_exclusive", 1, 0);
        if (if_b.mem_we) observe(1, K_WE, if_b.mem_addr, if_b.mem_wdata);
        if (if_b.mem_re) observe(1, K_RE, if_b.mem_addr, 8'h00);
        if (if_b.tx_valid && if_b.tx_ready) observe(1, K_TX, 8'h00, if_b.tx_data);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [9:0] w, output int t);
        t = cyc;
        if_a.rx_data  = w;
        if_a.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        if_a.rx_valid = 1'b0;
    endtask

    task automatic send_b(input logic [9:0] w, output int t);
        t = cyc;
        if_b.rx_data  = w;
        if_b.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        if_b.rx_valid = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'h00;
            ram_b[i] = 8'h00;
        end
        rst = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        if_a.rx_data = 10'h000; if_a.rx_valid = 1'b0; if_a.tx_ready = 1'b1;
        if_b.rx_data = 10'h000; if_b.rx_valid = 1'b0; if_b.tx_ready = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_a_tx_valid", {31'd0, if_a.tx_valid}, 0);
        chk("rst_a_tx_data",  {24'd0, if_a.tx_data}, 0);
        chk("rst_a_mem_addr", {24'd0, if_a.mem_addr}, 0);
        chk("rst_a_mem_wdata",{24'd0, if_a.mem_wdata}, 0);
        chk("rst_a_strobes",  {30'd0, if_a.mem_we, if_a.mem_re}, 0);
        chk("rst_a_status",   {29'd0, busy_a, overrun_a, rd_err_a}, 0);
        chk("rst_b_outputs",  {14'd0, if_b.tx_valid, if_b.tx_data, if_b.mem_addr, if_b.mem_we, if_b.mem_re}, 0);
        chk("rst_b_status",   {29'd0, busy_b, overrun_b, rd_err_b}, 0);

        // RD_DATA without a read address: rd_err, no access, then clear
        send_a(10'h300, t);
        chk("a_rd_err_set", {31'd0, rd_err_a}, 1);
        chk("a_rd_err_busy", {31'd0, busy_a}, 0);
        idle(2);
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        chk("a_rd_err_clr", {31'd0, rd_err_a}, 0);

        // Write 0xA5 to 0x3C
        send_a(10'h03C, t);
        push(0, K_WE, 8'h3C, 8'hA5, cyc + 1);
        send_a(10'h1A5, t);
        chk("a_busy_in_write", {31'd0, busy_a}, 1);
        idle(1);
        chk("a_idle_after_write", {31'd0, busy_a}, 0);

        // Read it back with RD_LAT=1 and tx_ready high
        send_a(10'h23C, t);
        push(0, K_RE, 8'h3C, 8'h00, cyc + 1);
        push(0, K_TX, 8'h00, 8'hA5, cyc + 3);
        send_a(10'h300, t);
        idle(2);
        chk("a_tx_valid_at_t3", {31'd0, if_a.tx_valid}, 1);
        idle(1);
        chk("a_tx_valid_drop", {31'd0, if_a.tx_valid}, 0);
        chk("a_no_overrun", {30'd0, overrun_a, rd_err_a}, 0);

        // AUTO_INC writes with wrap 0xFF -> 0x00
        send_b(10'h0FF, t);
        push(1, K_WE, 8'hFF, 8'h11, cyc + 1);
        send_b(10'h111, t);
        idle(1);
        push(1, K_WE, 8'h00, 8'h22, cyc + 1);
        send_b(10'h122, t);
        idle(1);

        // AUTO_INC reads with RD_LAT=3
        send_b(10'h2FF, t);
        push(1, K_RE, 8'hFF, 8'h00, cyc + 1);
        push(1, K_TX, 8'h00, 8'h11, cyc + 5);
        send_b(10'h300, t);
        idle(5);
        push(1, K_RE, 8'h00, 8'h00, cyc + 1);
        push(1, K_TX, 8'h00, 8'h22, cyc + 5);
        send_b(10'h300, t);
        idle(5);

        // tx back-pressure for 5 cycles, with an rx word dropped during TX
        if_b.tx_ready = 1'b0;
        send_b(10'h200, t);
        push(1, K_RE, 8'h00, 8'h00, cyc + 1);
        push(1, K_TX, 8'h00, 8'h22, cyc + 10);
        send_b(10'h300, t);
        idle(4);
        for (int i = 0; i < 5; i++) begin
            chk("b_stall_tx_valid", {31'd0, if_b.tx_valid}, 1);
            chk("b_stall_tx_data",  {24'd0, if_b.tx_data}, 32'h22);
            chk("b_stall_busy",     {31'd0, busy_b}, 1);
            if (i == 3) chk("b_overrun_set", {31'd0, overrun_b}, 1);
            if (i == 2) begin
                if_b.rx_data  = 10'h177;
                if_b.rx_valid = 1'b1;
            end
            idle(1);
            if_b.rx_valid = 1'b0;
        end
        if_b.tx_ready = 1'b1;
        idle(1);
        chk("b_tx_accepted", {31'd0, if_b.tx_valid}, 0);
        chk("b_overrun_sticky", {31'd0, overrun_b}, 1);
        clr_b = 1'b1;
        idle(1);
        clr_b = 1'b0;
        chk("b_overrun_clr", {31'd0, overrun_b}, 0);

        // Reset during RD_WAIT abandons the read and forgets the read address
        push(1, K_RE, 8'h01, 8'h00, cyc + 1);
        send_b(10'h300, t);
        idle(1);
        chk("b_in_rd_wait", {31'd0, busy_b}, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("b_rst_tx_valid", {31'd0, if_b.tx_valid}, 0);
        chk("b_rst_busy", {31'd0, busy_b}, 0);
        send_b(10'h300, t);
        chk("b_rd_err_after_rst", {31'd0, rd_err_b}, 1);
        chk("b_no_busy_after_rd_err", {31'd0, busy_b}, 0);
        idle(8);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command controller between the SPI slave's 10-bit receive word and a single-port 256x8 RAM.
- Decodes rx_data[9:8] into write-address, write-data, read-address and read-data commands.
- Sequences RAM write/read strobes and waits the RAM read latency.
- Returns read bytes to the SPI slave through a tx_valid/tx_ready handshake.
- Records protocol errors in sticky status flags.

Parameters:
RD_LAT, 1, RAM read latency in cycles from mem_re to valid mem_rdata; legal 1..4.
AUTO_INC, 0, 1 = post-increment the write address after each write and the read address after each read; wraps 255->0.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
rx_data  input  10  command word from SPI slave; [9:8] opcode, [7:0] payload
rx_valid  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  read byte to SPI slave
tx_valid  output  1  tx_data valid; held until accepted
tx_ready  input  1  SPI slave accepts tx_data when tx_valid && tx_ready
mem_addr  output  8  RAM address
mem_wdata  output  8  RAM write data
mem_we  output  1  RAM write strobe, one cycle
mem_re  output  1  RAM read strobe, one cycle
mem_rdata  input  8  RAM read data, valid RD_LAT cycles after mem_re
busy  output  1  high whenever the FSM is not in IDLE
overrun  output  1  sticky: rx_valid arrived while busy
rd_err  output  1  sticky: read-data command with no read address loaded
clr_status  input  1  clears overrun and rd_err (one-cycle pulse)

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; wr_addr and rd_addr clear to 0; rd_addr_ok clears to 0.
  - All outputs go to 0: tx_data, tx_valid, mem_*, busy, overrun, rd_err.
  - Reset mid-operation abandons any pending read or tx; no strobe occurs in the reset cycle.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, TX.
- IDLE: rx_valid is accepted only in this state. Decode on rx_data[9:8]:
  - 00 (WR_ADDR): wr_addr <= payload. Stay in IDLE. No RAM access.
  - 01 (WR_DATA): go to WRITE. Next cycle: mem_we=1, mem_addr=wr_addr, mem_wdata=payload. Then return to IDLE. If AUTO_INC=1, wr_addr+1 mod 256.
  - 10 (RD_ADDR): rd_addr <= payload; rd_addr_ok <= 1. Stay in IDLE.
  - 11 (RD_DATA), rd_addr_ok=1: go to RD_ISSUE.
  - 11 (RD_DATA), rd_addr_ok=0: rd_err <= 1, stay in IDLE, no RAM access, no tx.
- RD_ISSUE: mem_re=1, mem_addr=rd_addr for exactly one cycle. Then go to RD_WAIT.
- RD_WAIT:
  - Counts RD_LAT cycles starting the cycle after mem_re.
  - In the last count cycle, mem_rdata is registered into tx_data.
  - Then go to TX with tx_valid=1.
  - With RD_LAT=1: rx_valid in cycle T -> mem_re in T+1 -> tx_valid from T+3.
- TX:
  - tx_valid and tx_data stay stable until the cycle where tx_ready=1.
  - On that edge: tx_valid <= 0, go to IDLE. If AUTO_INC=1, rd_addr+1 mod 256.
  - rd_addr_ok stays 1, so repeated RD_DATA commands re-read the same address or the incremented one.
- Write latency: rx_valid in cycle T -> mem_we in T+1. In T+2 the controller is back in IDLE and accepts a new rx_valid.
- mem_addr, mem_wdata:
  - Outside strobe cycles, mem_addr holds its last driven value.
  - mem_wdata is don't-care when mem_we=0.
  - mem_we and mem_re are never high together.
- rx_valid while busy=1: the word is dropped, overrun <= 1, and the current operation completes unaffected.
- Status flags:
  - clr_status clears both flags.
  - If clr_status and a new error event occur in the same cycle, the set wins.
- tx_ready while tx_valid=0 is ignored.

Test Plan:
- Reset -> all outputs 0. rx 0x0_3C (WR_ADDR 0x3C) then 0x1_A5 (WR_DATA) -> mem_we pulse one cycle, mem_addr=0x3C, mem_wdata=0xA5, 1 cycle after the second rx_valid.
- RD_LAT=1, RAM preloaded [0x3C]=0xA5: rx 0x2_3C then 0x3_00; tx_ready held 1 -> mem_re at T+1 with addr 0x3C, tx_valid=1 with tx_data=0xA5 at T+3, low the next cycle.
- RD_LAT=3 with tx_ready held 0 for 5 cycles -> tx_valid high, tx_data stable throughout; busy=1; an rx_valid during TX sets overrun=1, word dropped, no RAM strobe.
- After reset, rx 0x3_00 with no RD_ADDR -> rd_err=1, no mem_re, no tx_valid. clr_status pulse -> rd_err=0.
- AUTO_INC=1: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> writes to 0xFF then 0x00 (wrap). RD_ADDR 0xFF plus two RD_DATA -> tx bytes 0x11, 0x22.
- rst asserted in RD_WAIT -> next cycle state IDLE, tx_valid=0, rd_addr_ok=0. A subsequent RD_DATA sets rd_err.
